// File: rtl/z80_bus_sequencer_if.sv
// Z80 IO bus bundle: CPU-side strobes and address in, per-channel chip selects
// with latched direction/address out towards the peripherals.
`timescale 1ns/1ps
interface z80_bus_if #(
    parameter int NCHAN = 2
);
    logic             iorq_b;
    logic             m1_b;
    logic             wr_b;
    logic [7:0]       ab_lo;
    logic [NCHAN-1:0] cs_b;
    logic             cs_rnw;
    logic [7:0]       cs_addr;

    modport master (
        output iorq_b, m1_b, wr_b, ab_lo,
        input  cs_b, cs_rnw, cs_addr
    );

    modport slave (
        input  iorq_b, m1_b, wr_b, ab_lo,
        output cs_b, cs_rnw, cs_addr
    );
endinterface

// File: rtl/z80_bus_sequencer.sv
// Clock divider with single-step, power-on reset sequencer and IO chip-select
// decoder sitting between the gate-level Z80 core and its peripherals.
`timescale 1ns/1ps
module z80_bus_sequencer #(
    parameter int                 HALFCYCLE = 100,
    parameter int                 RST_START = 1000,
    parameter int                 RST_END   = 2000,
    parameter int                 NCHAN     = 2,
    parameter logic [NCHAN*8-1:0] IO_BASE   = {8'hC0, 8'hAA},
    parameter logic [NCHAN*8-1:0] IO_MASK   = {8'hF0, 8'hFE}
) (
    input  logic    eclk,
    input  logic    reset_b,
    input  logic    soft_rst,
    input  logic    step_mode,
    input  logic    step_req,
    output logic    cpu_clk,
    output logic    cpu_reset_b,
    z80_bus_if.slave bus
);

    localparam int             IW     = $clog2(HALFCYCLE);
    localparam logic [IW-1:0]  I_LAST = IW'(HALFCYCLE - 1);

    logic [IW-1:0]    i_q, i_d;
    logic [31:0]      c_q, c_d;
    logic             cpu_clk_q, cpu_clk_d;
    logic             cpu_reset_b_q, cpu_reset_b_d;
    logic             iorq_prev_q, iorq_prev_d;
    logic             step_pending_q, step_pending_d;
    logic             step_req_prev_q, step_req_prev_d;
    logic [NCHAN-1:0] cs_b_q, cs_b_d;
    logic             cs_rnw_q, cs_rnw_d;
    logic [7:0]       cs_addr_q, cs_addr_d;

    logic [NCHAN-1:0] chan_hit;
    logic [NCHAN-1:0] chan_sel;
    logic             wrap, rise_evt, fall_evt, strobe, step_edge;

    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_decode
        assign chan_hit[gi] = ((bus.ab_lo ^ IO_BASE[8*gi +: 8]) & IO_MASK[8*gi +: 8]) == 8'h00;
    end

    // Isolate the lowest set bit so overlapping windows resolve to the lowest channel.
    assign chan_sel = chan_hit & (~chan_hit + NCHAN'(1));

    assign wrap      = (i_q == I_LAST);
    assign rise_evt  = wrap && !cpu_clk_q && (!step_mode || step_pending_q);
    assign fall_evt  = wrap && cpu_clk_q;
    assign strobe    = rise_evt && iorq_prev_q && !bus.iorq_b && bus.m1_b;
    assign step_edge = step_req && !step_req_prev_q;

    always_comb begin
        i_d             = i_q + IW'(1);
        cpu_clk_d       = cpu_clk_q;
        c_d             = (c_q == 32'hFFFF_FFFF) ? c_q : c_q + 32'd1;
        cpu_reset_b_d   = cpu_reset_b_q;
        iorq_prev_d     = iorq_prev_q;
        step_pending_d  = (step_pending_q && !rise_evt) || step_edge;
        step_req_prev_d = step_req;
        cs_b_d          = '1;
        cs_rnw_d        = cs_rnw_q;
        cs_addr_d       = cs_addr_q;

        // A blocked rising toggle parks the divider on its last count.
        if (wrap) begin
            i_d = (rise_evt || fall_evt) ? '0 : I_LAST;
        end
        if (rise_evt || fall_evt) begin
            cpu_clk_d = !cpu_clk_q;
        end

        if (c_q == 32'(RST_START)) cpu_reset_b_d = 1'b0;
        if (c_q == 32'(RST_END))   cpu_reset_b_d = 1'b1;

        if (rise_evt) begin
            iorq_prev_d = bus.iorq_b;
        end
        if (strobe && (|chan_hit)) begin
            cs_b_d    = ~chan_sel;
            cs_rnw_d  = bus.wr_b;
            cs_addr_d = bus.ab_lo;
        end

        if (soft_rst) begin
            i_d             = '0;
            cpu_clk_d       = 1'b0;
            c_d             = '0;
            cpu_reset_b_d   = 1'b1;
            iorq_prev_d     = 1'b1;
            step_pending_d  = 1'b0;
            step_req_prev_d = 1'b0;
            cs_b_d          = '1;
            cs_rnw_d        = 1'b1;
            cs_addr_d       = 8'h00;
        end
    end

    always_ff @(posedge eclk or negedge reset_b) begin
        if (!reset_b) begin
            i_q             <= '0;
            cpu_clk_q       <= 1'b0;
            c_q             <= '0;
            cpu_reset_b_q   <= 1'b1;
            iorq_prev_q     <= 1'b1;
            step_pending_q  <= 1'b0;
            step_req_prev_q <= 1'b0;
            cs_b_q          <= '1;
            cs_rnw_q        <= 1'b1;
            cs_addr_q       <= 8'h00;
        end else begin
            i_q             <= i_d;
            cpu_clk_q       <= cpu_clk_d;
            c_q             <= c_d;
            cpu_reset_b_q   <= cpu_reset_b_d;
            iorq_prev_q     <= iorq_prev_d;
            step_pending_q  <= step_pending_d;
            step_req_prev_q <= step_req_prev_d;
            cs_b_q          <= cs_b_d;
            cs_rnw_q        <= cs_rnw_d;
            cs_addr_q       <= cs_addr_d;
        end
    end

    assign cpu_clk     = cpu_clk_q;
    assign cpu_reset_b = cpu_reset_b_q;
    assign bus.cs_b    = cs_b_q;
    assign bus.cs_rnw  = cs_rnw_q;
    assign bus.cs_addr = cs_addr_q;

endmodule

// File: tb/tb_z80_bus_sequencer.sv
// Directed bench for z80_bus_sequencer: divider, reset sequence, soft reset,
// IO chip-select scoreboard and single-step behaviour.
`timescale 1ns/1ps
module tb_z80_bus_sequencer;

    logic eclk = 1'b0;
    logic reset_b, soft_rst, step_mode, step_req;
    logic cpu_clk, cpu_reset_b;

    z80_bus_if #(.NCHAN(2)) bus ();

    z80_bus_sequencer #(
        .HALFCYCLE (4),
        .RST_START (10),
        .RST_END   (20),
        .NCHAN     (2),
        .IO_BASE   ({8'hC0, 8'hAA}),
        .IO_MASK   ({8'hF0, 8'hFE})
    ) dut (
        .eclk        (eclk),
        .reset_b     (reset_b),
        .soft_rst    (soft_rst),
        .step_mode   (step_mode),
        .step_req    (step_req),
        .cpu_clk     (cpu_clk),
        .cpu_reset_b (cpu_reset_b),
        .bus         (bus)
    );

    always #5 eclk = ~eclk;

    typedef struct packed {
        logic [1:0] cs;
        logic       rnw;
        logic [7:0] addr;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         pulses = 0;
    logic [1:0] prev_cs = 2'b11;
    logic       prev_clk = 1'b0;
    logic       rose = 1'b0;
    logic       m_rnw = 1'b1;
    logic [7:0] m_addr = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every eclk edge goes through here so chip-select pulses are never missed.
    task automatic tick();
        exp_t e;
        @(posedge eclk);
        #1;
        rose = (cpu_clk === 1'b1) && (prev_clk === 1'b0);
        if (bus.cs_b !== 2'b11) begin
            pulses++;
            chk("pulse_width", {30'd0, prev_cs}, 32'h3);
            chk("pulse_on_rise", {31'd0, rose}, 32'h1);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, bus.cs_b}, 32'h3);
            end else begin
                e = sb.pop_front();
                chk("cs_b", {30'd0, bus.cs_b}, {30'd0, e.cs});
                chk("cs_rnw", {31'd0, bus.cs_rnw}, {31'd0, e.rnw});
                chk("cs_addr", {24'd0, bus.cs_addr}, {24'd0, e.addr});
                $display("PULSE cs_b=%b cs_rnw=%0b cs_addr=%02h", bus.cs_b, bus.cs_rnw, bus.cs_addr);
            end
        end
        prev_cs  = bus.cs_b;
        prev_clk = cpu_clk;
    endtask

    task automatic wait_rises(input int n);
        int got = 0;
        for (int t = 0; t < 40 * n && got < n; t++) begin
            tick();
            if (rose) got++;
        end
        chk("rise_count", got, n);
    endtask

    task automatic io(input logic [7:0] a, input logic w, input logic m1, input int holds,
                      input logic exp_pulse, input logic [1:0] exp_cs);
        int p0 = pulses;
        wait_rises(1);
        bus.iorq_b = 1'b0;
        bus.m1_b   = m1;
        bus.wr_b   = w;
        bus.ab_lo  = a;
        if (exp_pulse) begin
            sb.push_back('{exp_cs, w, a});
            m_rnw  = w;
            m_addr = a;
        end
        wait_rises(holds);
        bus.iorq_b = 1'b1;
        bus.m1_b   = 1'b1;
        bus.wr_b   = 1'b1;
        wait_rises(1);
        tick();
        chk("pulse_count", pulses - p0, exp_pulse ? 1 : 0);
        chk("sb_drained", sb.size(), 0);
        chk("cs_rnw_hold", {31'd0, bus.cs_rnw}, {31'd0, m_rnw});
        chk("cs_addr_hold", {24'd0, bus.cs_addr}, {24'd0, m_addr});
        $display("IO addr=%02h wr_b=%0b m1_b=%0b holds=%0d pulses=%0d", a, w, m1, holds, pulses - p0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_clk"}, {31'd0, cpu_clk}, 32'h0);
        chk({tag, "_cpu_reset_b"}, {31'd0, cpu_reset_b}, 32'h1);
        chk({tag, "_cs_b"}, {30'd0, bus.cs_b}, 32'h3);
        chk({tag, "_cs_rnw"}, {31'd0, bus.cs_rnw}, 32'h1);
        chk({tag, "_cs_addr"}, {24'd0, bus.cs_addr}, 32'h0);
    endtask

    // After edge k of a fresh sequence: clock high in phases 4..7 of 8, reset low for 11..20.
    task automatic check_sequence(input int kmax);
        for (int k = 1; k <= kmax; k++) begin
            tick();
            chk($sformatf("clk_k%0d", k), {31'd0, cpu_clk}, ((k >> 2) & 1));
            chk($sformatf("rstb_k%0d", k), {31'd0, cpu_reset_b}, (k >= 11 && k <= 20) ? 0 : 1);
        end
    endtask

    initial begin
        int highs;
        int rises;
        reset_b    = 1'b0;
        soft_rst   = 1'b0;
        step_mode  = 1'b0;
        step_req   = 1'b0;
        bus.iorq_b = 1'b1;
        bus.m1_b   = 1'b1;
        bus.wr_b   = 1'b1;
        bus.ab_lo  = 8'h00;
        #12;
        check_reset_outputs("por");
        @(negedge eclk);
        reset_b = 1'b1;
        check_sequence(24);
        $display("SEQ power-on sequence checked");

        // Soft reset in the middle of the low window, held for three edges.
        @(negedge eclk);
        reset_b = 1'b0;
        #1;
        prev_clk = cpu_clk;
        @(negedge eclk);
        reset_b = 1'b1;
        check_sequence(14);
        soft_rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            check_reset_outputs("soft");
        end
        soft_rst = 1'b0;
        check_sequence(22);
        $display("SEQ soft reset restart checked");

        io(8'hAB, 1'b0, 1'b1, 1, 1'b1, 2'b10);
        io(8'hC5, 1'b1, 1'b0, 1, 1'b0, 2'b11);
        io(8'hC5, 1'b1, 1'b1, 1, 1'b1, 2'b01);
        io(8'h10, 1'b0, 1'b1, 1, 1'b0, 2'b11);
        io(8'hAA, 1'b1, 1'b1, 3, 1'b1, 2'b10);

        // Step mode with no request: clock parks low.
        step_mode = 1'b1;
        for (int t = 0; t < 10 && cpu_clk !== 1'b0; t++) tick();
        highs = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (cpu_clk === 1'b1) highs++;
        end
        chk("step_stuck_low", highs, 0);
        $display("STEP no request highs=%0d", highs);

        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        rises = 0;
        for (int t = 0; t < 10 && rises == 0; t++) begin
            tick();
            if (rose) rises++;
        end
        chk("step_single_rise", rises, 1);

        // Two request edges during the granted high phase collapse into one more step.
        step_req = 1'b1; tick();
        step_req = 1'b0; tick();
        step_req = 1'b1; tick();
        step_req = 1'b0;
        highs = 0;
        rises = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (rose) rises++;
            if (cpu_clk === 1'b1) highs++;
        end
        chk("step_double_rises", rises, 1);
        chk("step_double_highs", highs, 4);
        $display("STEP double request rises=%0d highs=%0d", rises, highs);

        // Reset in the middle of a high phase with another step already pending.
        step_req = 1'b1; tick();
        step_req = 1'b0; tick();
        chk("step_mid_high", {31'd0, cpu_clk}, 32'h1);
        tick();
        step_req = 1'b1; tick();
        #3;
        reset_b  = 1'b0;
        step_req = 1'b0;
        #1;
        check_reset_outputs("mid");
        prev_clk = cpu_clk;
        prev_cs  = bus.cs_b;
        m_rnw    = 1'b1;
        m_addr   = 8'h00;
        @(negedge eclk);
        reset_b = 1'b1;
        highs = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (cpu_clk === 1'b1) highs++;
        end
        chk("step_pending_lost", highs, 0);
        step_mode = 1'b0;
        tick();
        chk("resume_wrap", {31'd0, cpu_clk}, 32'h1);
        $display("STEP reset mid-phase highs=%0d resume=%0b", highs, cpu_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
